// File: rtl/ccff_bitstream_loader.sv
// Serialises host configuration words LSB-first onto the configuration-chain head.
// Optional tail readback (rb_data/rb_valid) is built when CCFF_READBACK_EN is defined.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 256,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count
`ifdef CCFF_READBACK_EN
    ,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
`endif
);

    localparam int WC_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] shreg;
    logic [WC_W-1:0]   word_cnt;
    logic              last_bit;
    logic              word_end;
    logic              start_load;

    assign last_bit   = (bit_count == CNT_W'(CHAIN_LEN - 1));
    assign word_end   = (word_cnt == WC_W'(WORD_W - 1));
    assign start_load = start && !abort && (state == IDLE || state == DONE);
    assign ccff_head  = ccff_shift_en && shreg[0];

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        cfg_ready     = 1'b0;
        ccff_shift_en = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: begin
                busy      = 1'b1;
                cfg_ready = 1'b1;
                if (cfg_valid) state_next = SHIFT;
            end
            SHIFT: begin
                busy          = 1'b1;
                ccff_shift_en = 1'b1;
                if (last_bit)      state_next = DONE;
                else if (word_end) state_next = LOAD;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = LOAD;
            end
            default: state_next = IDLE;
        endcase
        // Abort freezes the chain in the very cycle it is raised.
        if (abort) begin
            state_next    = IDLE;
            cfg_ready     = 1'b0;
            ccff_shift_en = 1'b0;
            done          = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state     <= IDLE;
            shreg     <= '0;
            word_cnt  <= '0;
            bit_count <= '0;
        end else begin
            state <= state_next;
            if (start_load)
                bit_count <= '0;
            else if (ccff_shift_en && bit_count != CNT_W'(CHAIN_LEN))
                bit_count <= bit_count + 1'b1;
            if (cfg_ready && cfg_valid) begin
                shreg    <= cfg_data;
                word_cnt <= '0;
            end else if (ccff_shift_en) begin
                shreg    <= shreg >> 1;
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] rb_acc;
    logic [WORD_W-1:0] rb_acc_next;
    logic [WC_W-1:0]   rb_cnt;

    always_comb begin
        rb_acc_next         = rb_acc;
        rb_acc_next[rb_cnt] = ccff_tail;
    end

    // Accumulator restarts from zero after each emission, which zero-pads a short final word.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            rb_acc   <= '0;
            rb_cnt   <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (abort || start_load) begin
                rb_acc <= '0;
                rb_cnt <= '0;
            end else if (ccff_shift_en) begin
                if (rb_cnt == WC_W'(WORD_W - 1) || last_bit) begin
                    rb_data  <= rb_acc_next;
                    rb_valid <= 1'b1;
                    rb_acc   <= '0;
                    rb_cnt   <= '0;
                end else begin
                    rb_acc <= rb_acc_next;
                    rb_cnt <= rb_cnt + 1'b1;
                end
            end
        end
    end
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Randomised scoreboard bench for ccff_bitstream_loader (20-bit chain, 8-bit words).
// Build with CCFF_READBACK_EN defined to also check the tail readback path.
module tb_ccff_bitstream_loader;

    localparam int CHAIN_LEN = 20;
    localparam int WORD_W    = 8;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
    localparam int NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;

    logic              prog_clk = 1'b0;
    logic              prog_reset;
    logic              start;
    logic              abort;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              ccff_head;
    logic              ccff_shift_en;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  bit_count;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];
    int mon_idx;
    bit mon_en;

`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0]    rb_data;
    logic                 rb_valid;
    logic [CHAIN_LEN-1:0] chain;
    logic [WORD_W-1:0]    rb_q[$];
    bit                   rb_en;
`endif

    always #5 prog_clk = ~prog_clk;

    ccff_bitstream_loader #(
        .CHAIN_LEN(CHAIN_LEN),
        .WORD_W   (WORD_W)
    ) dut (
        .prog_clk     (prog_clk),
        .prog_reset   (prog_reset),
        .start        (start),
        .abort        (abort),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .ccff_head    (ccff_head),
        .ccff_shift_en(ccff_shift_en),
        .ccff_tail    (ccff_tail),
        .busy         (busy),
        .done         (done),
        .bit_count    (bit_count)
`ifdef CCFF_READBACK_EN
        ,
        .rb_data      (rb_data),
        .rb_valid     (rb_valid)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Head monitor: every shift cycle must present the next expected bit.
    always @(negedge prog_clk) begin
        if (mon_en) begin
            if (ccff_shift_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_shift", 32'd1, 32'd0);
                end else begin
                    check("ccff_head", ccff_head, exp_q.pop_front());
                    check("bit_count_at_shift", bit_count, mon_idx);
                    mon_idx++;
                end
            end else begin
                check("head_zero_without_shift", ccff_head, 0);
            end
        end
    end

`ifdef CCFF_READBACK_EN
    // External chain model: head enters at the top, the tail leaves from bit 0.
    assign ccff_tail = chain[0];
    always @(posedge prog_clk)
        if (ccff_shift_en) chain <= {ccff_head, chain[CHAIN_LEN-1:1]};

    always @(negedge prog_clk) begin
        if (rb_en && rb_valid) begin
            if (rb_q.size() == 0) check("rb_unexpected", 32'd1, 32'd0);
            else                  check("rb_data", rb_data, rb_q.pop_front());
        end
    end
`else
    assign ccff_tail = 1'b0;
`endif

    task automatic check_all_zero(input string tag);
        check({tag, "_cfg_ready"}, cfg_ready, 0);
        check({tag, "_shift_en"}, ccff_shift_en, 0);
        check({tag, "_head"}, ccff_head, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_bit_count"}, bit_count, 0);
`ifdef CCFF_READBACK_EN
        check({tag, "_rb_valid"}, rb_valid, 0);
        check({tag, "_rb_data"}, rb_data, 0);
`endif
    endtask

    // Host-side valid traffic without a start must never be consumed.
    task automatic idle_ignore(input int n);
        cfg_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            cfg_data = WORD_W'($urandom);
            @(negedge prog_clk);
            check("idle_cfg_ready", cfg_ready, 0);
            check("idle_busy", busy, 0);
            @(posedge prog_clk); #1;
        end
        cfg_valid = 1'b0;
    endtask

    // One load. kill_at < 0 runs to completion; otherwise abort (or reset) is raised
    // once kill_at bits have been shifted.
    task automatic run_load(input int kill_at, input bit use_reset, input int stall_pct);
        logic [WORD_W-1:0] words[NW];
        int n_bits, wi, shifted, cycles;
        bit acc, kill, fin;
`ifdef CCFF_READBACK_EN
        logic [CHAIN_LEN-1:0] snap;
        logic [WORD_W-1:0]    rw;
        int                   n_rb;
`endif
        for (int i = 0; i < NW; i++) words[i] = WORD_W'($urandom);
        n_bits = (kill_at >= 0) ? kill_at : CHAIN_LEN;
        for (int k = 0; k < n_bits; k++) exp_q.push_back(words[k / WORD_W][k % WORD_W]);
`ifdef CCFF_READBACK_EN
        snap = chain;
        n_rb = (n_bits == CHAIN_LEN) ? NW : n_bits / WORD_W;
        for (int w = 0; w < n_rb; w++) begin
            rw = '0;
            for (int j = 0; j < WORD_W; j++)
                if (w * WORD_W + j < n_bits) rw[j] = snap[w * WORD_W + j];
            rb_q.push_back(rw);
        end
`endif
        mon_idx   = 0;
        start     = 1'b1;
        cfg_valid = 1'b0;
        @(posedge prog_clk); #1;
        wi = 0; shifted = 0; cycles = 0; fin = 0;
        while (!fin) begin
            cfg_valid = (wi < NW) && ($urandom_range(99) >= stall_pct);
            if (cfg_valid) cfg_data = words[wi];
            else           cfg_data = WORD_W'($urandom);
            start = ($urandom_range(4) == 0);
            kill  = (kill_at >= 0) && (shifted == kill_at);
            if (kill) begin
                if (use_reset) begin
                    prog_reset = 1'b1;
                    mon_en     = 1'b0;
`ifdef CCFF_READBACK_EN
                    rb_en = 1'b0;
`endif
                end else begin
                    abort = 1'b1;
                end
            end
            @(negedge prog_clk);
            if (cycles == 0) check("start_clears_count", bit_count, 0);
            acc = cfg_valid && cfg_ready;
            if (cfg_ready && !cfg_valid) check("stall_count_frozen", bit_count, wi * WORD_W);
            if (kill && !use_reset) begin
                check("abort_shift_en", ccff_shift_en, 0);
                check("abort_done", done, 0);
            end
            if (ccff_shift_en) shifted++;
            @(posedge prog_clk); #1;
            cycles++;
            if (acc) wi++;
            if (kill) fin = 1;
            else if (shifted == CHAIN_LEN) fin = 1;
            else if (cycles > 400) begin
                check("load_timeout", shifted, CHAIN_LEN);
                fin = 1;
            end
        end
        start = 1'b0; cfg_valid = 1'b0; abort = 1'b0; prog_reset = 1'b0;
        @(negedge prog_clk);
        if (kill_at < 0) begin
            if (stall_pct == 0) check("load_cycles", cycles, NW + CHAIN_LEN);
            check("done_after_load", done, 1);
            check("busy_after_load", busy, 0);
            check("cfg_ready_after_load", cfg_ready, 0);
            check("bit_count_final", bit_count, CHAIN_LEN);
            check("bits_all_shifted", exp_q.size(), 0);
        end else if (!use_reset) begin
            check("done_after_abort", done, 0);
            check("busy_after_abort", busy, 0);
            check("bit_count_after_abort", bit_count, kill_at);
            check("bits_before_abort", exp_q.size(), 0);
        end else begin
            check_all_zero("after_reset");
            exp_q.delete();
            mon_en = 1'b1;
`ifdef CCFF_READBACK_EN
            rb_q.delete();
            rb_en = 1'b1;
`endif
        end
        @(posedge prog_clk); #1;
`ifdef CCFF_READBACK_EN
        @(negedge prog_clk);
        check("rb_words_all_seen", rb_q.size(), 0);
        @(posedge prog_clk); #1;
`endif
    endtask

    initial begin
        prog_reset = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_valid = 1'b0; cfg_data = '0; mon_en = 1'b1;
`ifdef CCFF_READBACK_EN
        chain = CHAIN_LEN'($urandom);
        rb_en = 1'b1;
`endif
        repeat (2) @(posedge prog_clk);
        #1 prog_reset = 1'b0;
        @(negedge prog_clk);
        check_all_zero("reset");
        @(posedge prog_clk); #1;

        idle_ignore(4);
        run_load(-1, 0, 0);

        // DONE holds, bit_count saturated, host traffic ignored.
        cfg_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge prog_clk);
            check("done_hold", done, 1);
            check("done_count_hold", bit_count, CHAIN_LEN);
            check("done_cfg_ready", cfg_ready, 0);
            @(posedge prog_clk); #1;
        end
        cfg_valid = 1'b0;

        run_load(-1, 0, 40);
        run_load(11, 0, 0);
        run_load(-1, 0, 20);
        run_load(8, 0, 30);
        run_load(0, 0, 0);
        run_load(-1, 0, 0);

        // abort and start together in DONE: abort wins, count is not cleared.
        start = 1'b1; abort = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge prog_clk);
        check("abort_start_done", done, 0);
        check("abort_start_busy", busy, 0);
        check("abort_start_count", bit_count, CHAIN_LEN);
        @(posedge prog_clk); #1;
        @(negedge prog_clk);
        check("abort_start_idle_ready", cfg_ready, 0);
        @(posedge prog_clk); #1;

        run_load(13, 1, 0);
        idle_ignore(3);
        run_load(-1, 0, 0);

        for (int r = 0; r < 8; r++) begin
            int  ka;
            bit  ur;
            ka = ($urandom_range(2) == 0) ? int'($urandom_range(CHAIN_LEN - 1)) : -1;
            ur = (ka >= 0) && ($urandom_range(3) == 0);
            run_load(ka, ur, int'($urandom_range(50)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Upstream feeder for the configuration-chain head of the I/O and logic tiles.
- Accepts configuration words from the host-side programming interface over a valid/ready handshake and serialises them LSB-first onto ccff_head.
- Drives a per-cycle shift enable for the external prog_clk gate, so the chain advances only when a valid bit is presented.
- Counts exactly CHAIN_LEN bits, then signals completion.

Parameters:
- CHAIN_LEN, 256, total configuration bits in the chain (≥1).
- WORD_W, 8, host word width (≥2).
- CNT_W, $clog2(CHAIN_LEN+1), bit-counter width (derived; do not override).

Ports:
- prog_clk  input  1  programming clock; sole clock.
- prog_reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load.
- abort  input  1  cancels any load in progress.
- cfg_data  input  WORD_W  configuration word; bit 0 is shifted first.
- cfg_valid  input  1  cfg_data is valid.
- cfg_ready  output  1  loader accepts cfg_data this cycle.
- ccff_head  output  1  serial bit into the chain head.
- ccff_shift_en  output  1  chain must shift on the next prog_clk edge.
- ccff_tail  input  1  chain tail; used only by the optional feature.
- busy  output  1  high in LOAD and SHIFT states.
- done  output  1  CHAIN_LEN bits shifted; held high.
- bit_count  output  CNT_W  bits shifted since the last start.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high. Clock port is prog_clk, reset port is prog_reset.
- Reset: state IDLE; shift register, bit_count, cfg_ready, ccff_head, ccff_shift_en, busy and done all 0.
- IDLE:
  - start=1 → LOAD; bit_count cleared to 0; done cleared.
- LOAD:
  - cfg_ready=1, ccff_shift_en=0.
  - cfg_valid & cfg_ready → capture cfg_data into the shift register, clear the in-word counter, go to SHIFT.
  - cfg_valid=0 → stay in LOAD; the chain holds.
- SHIFT:
  - cfg_ready=0, ccff_shift_en=1, ccff_head = shreg[0].
  - Each cycle: shreg >>= 1, in-word counter +1, bit_count +1.
  - When bit_count reaches CHAIN_LEN → DONE.
  - Otherwise, after WORD_W bits → LOAD.
  - Each full word therefore costs WORD_W+1 cycles (one LOAD bubble with shift_en=0).
- Partial final word: if CHAIN_LEN mod WORD_W ≠ 0, the unused upper bits of the last word are discarded and never shifted.
- DONE:
  - done=1, busy=0, cfg_ready=0, shift_en=0.
  - start → LOAD (reload: bit_count cleared, done cleared).
- start outside IDLE/DONE: ignored.
- abort (any state, highest priority after prog_reset): → IDLE next cycle; shift_en=0 and done=0 that cycle. The chain keeps whatever partial bits it received.
- abort and start in the same cycle: abort wins.
- cfg_valid while cfg_ready=0: ignored; no data is consumed.
- ccff_head is combinational from shreg[0] and is 0 whenever shift_en=0.
- bit_count saturates at CHAIN_LEN.

Optional Feature:
- Macro: CCFF_READBACK_EN.
- When defined, the loader adds outputs rb_data[WORD_W-1:0] and rb_valid:
  - In every cycle with ccff_shift_en=1, ccff_tail is sampled, i.e. the previous configuration bit leaving the chain.
  - Samples are packed LSB-first into rb_data.
  - rb_valid pulses for one cycle when WORD_W bits are packed, or when the final bit (bit_count=CHAIN_LEN) is packed. A final partial word is zero-padded in its upper bits.
  - There is no backpressure. rb_data and rb_valid reset to 0, and the packing counter clears on start and on abort.
- When not defined: ports and logic are absent, and ccff_tail is unused.

Test Plan:
- Basic load, CHAIN_LEN=16, WORD_W=8: start, then words 0xA5 and 0x3C with cfg_valid held high → ccff_head sequence 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0. shift_en high for exactly 16 cycles with one low bubble between words. done=1 and bit_count=16.
- Partial word, CHAIN_LEN=12: words 0xFF and 0x0F → exactly 12 shift_en cycles. Bits 4-7 of the second word are never driven. done asserts after the 12th bit.
- Host stall: cfg_valid low for 5 cycles between words → cfg_ready stays high and shift_en stays 0 for all 5 cycles. bit_count frozen at 8; the output sequence is unchanged.
- Abort mid-word after 3 bits of the second word: abort=1 → next cycle IDLE, shift_en=0, done=0, bit_count holds 11. A new start clears bit_count to 0.
- Reset mid-SHIFT: prog_reset for 1 cycle → all outputs 0 on the following cycle. start with cfg_valid asserted before reset → ignored until start.
- CCFF_READBACK_EN: model the chain as a 16-bit shift register preloaded with 0x1234, then load 16 bits → rb_valid pulses twice, with rb_data 0x34 then 0x12. Afterwards the model holds the newly loaded pattern.
